// File: rtl/ciaa_ps2_cmd_sched_pkg.sv
// ----------------------------------------------------------------------------
// ciaa_ps2_cmd_sched_pkg
// Shared constants and types for the PS/2 host-to-keyboard command scheduler.
//   PS2_ACK / PS2_RESEND / PS2_SETLED : keyboard protocol bytes
//   state_e                           : scheduler FSM state encoding
//   is_tx_state / is_ack_state        : state class helpers
// ----------------------------------------------------------------------------
package ciaa_ps2_cmd_sched_pkg;

    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_SETLED = 8'hED;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TX_CMD  = 3'd1,
        ST_ACK_CMD = 3'd2,
        ST_TX_ARG  = 3'd3,
        ST_ACK_ARG = 3'd4,
        ST_DONE    = 3'd5,
        ST_FAIL    = 3'd6
    } state_e;

    function automatic logic is_tx_state(input state_e s);
        return (s == ST_TX_CMD) || (s == ST_TX_ARG);
    endfunction

    function automatic logic is_ack_state(input state_e s);
        return (s == ST_ACK_CMD) || (s == ST_ACK_ARG);
    endfunction

endpackage

// File: rtl/ciaa_ps2_cmd_sched_if.sv
// ----------------------------------------------------------------------------
// ciaa_ps2_cmd_sched_if
// Byte-level link between the command scheduler and the PS/2 PHY.
//   phy_tx_req   : one-tick pulse, PHY starts sending phy_tx_byte
//   phy_tx_byte  : byte to send
//   phy_tx_done  : one-tick pulse, PHY finished sending
//   phy_rx_valid : one-tick pulse, phy_rx_byte holds a received byte
//   phy_rx_byte  : received byte
// master = scheduler side, slave = PHY side.
// ----------------------------------------------------------------------------
interface ciaa_ps2_cmd_sched_if;

    logic       phy_tx_req;
    logic [7:0] phy_tx_byte;
    logic       phy_tx_done;
    logic       phy_rx_valid;
    logic [7:0] phy_rx_byte;

    modport master (
        output phy_tx_req,
        output phy_tx_byte,
        input  phy_tx_done,
        input  phy_rx_valid,
        input  phy_rx_byte
    );

    modport slave (
        input  phy_tx_req,
        input  phy_tx_byte,
        output phy_tx_done,
        output phy_rx_valid,
        output phy_rx_byte
    );

endinterface

// File: rtl/ciaa_ps2_ack_timer.sv
// ----------------------------------------------------------------------------
// ciaa_ps2_ack_timer
// Acknowledge timeout counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   ce         : clock enable, counter only moves when high
//   clr        : restart the count from zero
//   run        : count this tick
//   expired    : high on the 2^TO_W-th running tick since the last clear
// ----------------------------------------------------------------------------
module ciaa_ps2_ack_timer #(
    parameter int TO_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic clr,
    input  logic run,
    output logic expired
);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (ce) begin
            cnt_q <= cnt_d;
        end
    end

    // The first running tick sees 0, so all-ones marks the 2^TO_W-th tick.
    assign expired = run & (&cnt_q);

endmodule

// File: rtl/ciaa_ps2_cmd_sched.sv
// ----------------------------------------------------------------------------
// ciaa_ps2_cmd_sched
// Host-to-keyboard command scheduler sitting between the PS/2 PHY and the
// keymap. Arbitrates the LED updater and the host command port, sends
// cmd[+arg], waits for ACK (0xFA), resends on 0xFE, times out on silence.
// Every received byte not consumed as an ACK/RESEND is forwarded to the keymap.
//   clk, _reset   : clock, asynchronous active-low reset
//   clk7_en       : clock enable, all state advances only when high
//   led_bits      : wanted {caps,num,scroll}
//   host_req/cmd/arg/has_arg : host command request (level until host_done)
//   host_done/host_err       : completion pulse, err qualifies failure
//   phy           : PHY byte link (master side)
//   scan_valid/scan_byte     : forwarded received bytes
//   busy          : FSM not idle
// ----------------------------------------------------------------------------
module ciaa_ps2_cmd_sched
    import ciaa_ps2_cmd_sched_pkg::*;
#(
    parameter int TO_W      = 16,
    parameter int MAX_RETRY = 3,
    parameter int REF_W     = 20
) (
    input  logic                        clk,
    input  logic                        _reset,
    input  logic                        clk7_en,
    input  logic [2:0]                  led_bits,
    input  logic                        host_req,
    input  logic [7:0]                  host_cmd,
    input  logic [7:0]                  host_arg,
    input  logic                        host_has_arg,
    output logic                        host_done,
    output logic                        host_err,
    ciaa_ps2_cmd_sched_if.master        phy,
    output logic                        scan_valid,
    output logic [7:0]                  scan_byte,
    output logic                        busy
);

    localparam int RET_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    state_e             state_q, state_d;
    logic [RET_W-1:0]   retry_q, retry_d;
    logic [7:0]         cmd_q, cmd_d;
    logic [7:0]         arg_q, arg_d;
    logic               has_arg_q, has_arg_d;
    logic               grant_led_q, grant_led_d;
    logic               last_host_q, last_host_d;
    logic [2:0]         led_sent_q, led_sent_d;
    logic               led_pend_q, led_pend_d;
    logic [REF_W-1:0]   ref_q;
    logic               tx_req_q, tx_req_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic               host_done_q, host_done_d;
    logic               host_err_q, host_err_d;
    logic               scan_valid_q, scan_valid_d;
    logic [7:0]         scan_byte_q, scan_byte_d;

    logic led_want;
    logic led_grant;
    logic rx_ack;
    logic rx_resend;
    logic rx_consume;
    logic timer_clr;
    logic timer_exp;

    // The mismatch term is looked at directly so an LED change arriving in the
    // same tick as a host request takes part in that tick's arbitration.
    assign led_want  = led_pend_q | (led_bits != led_sent_q) | (&ref_q);
    assign rx_ack    = phy.phy_rx_valid && (phy.phy_rx_byte == PS2_ACK);
    assign rx_resend = phy.phy_rx_valid && (phy.phy_rx_byte == PS2_RESEND);

    ciaa_ps2_ack_timer #(.TO_W(TO_W)) u_ack_timer (
        .clk     (clk),
        .rst_n   (_reset),
        .ce      (clk7_en),
        .clr     (timer_clr),
        .run     (is_ack_state(state_q)),
        .expired (timer_exp)
    );

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        has_arg_d   = has_arg_q;
        grant_led_d = grant_led_q;
        last_host_d = last_host_q;
        led_sent_d  = led_sent_q;
        led_grant   = 1'b0;
        rx_consume  = 1'b0;
        timer_clr   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                timer_clr = 1'b1;
                // On contention the requester not served last time wins.
                if (led_want && (!host_req || last_host_q)) begin
                    led_grant   = 1'b1;
                    grant_led_d = 1'b1;
                    last_host_d = 1'b0;
                    cmd_d       = PS2_SETLED;
                    arg_d       = {5'b0, led_bits};
                    has_arg_d   = 1'b1;
                    led_sent_d  = led_bits;
                    retry_d     = '0;
                    state_d     = ST_TX_CMD;
                end else if (host_req) begin
                    grant_led_d = 1'b0;
                    last_host_d = 1'b1;
                    cmd_d       = host_cmd;
                    arg_d       = host_arg;
                    has_arg_d   = host_has_arg;
                    retry_d     = '0;
                    state_d     = ST_TX_CMD;
                end
            end
            ST_TX_CMD, ST_TX_ARG: begin
                timer_clr = 1'b1;
                if (phy.phy_tx_done) begin
                    state_d = (state_q == ST_TX_CMD) ? ST_ACK_CMD : ST_ACK_ARG;
                end
            end
            ST_ACK_CMD, ST_ACK_ARG: begin
                if (rx_ack) begin
                    rx_consume = 1'b1;
                    if ((state_q == ST_ACK_CMD) && has_arg_q) begin
                        retry_d = '0;
                        state_d = ST_TX_ARG;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (rx_resend) begin
                    rx_consume = 1'b1;
                    if (retry_q < RET_W'(MAX_RETRY)) begin
                        retry_d = retry_q + RET_W'(1);
                        state_d = (state_q == ST_ACK_CMD) ? ST_TX_CMD : ST_TX_ARG;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end else if (!phy.phy_rx_valid && timer_exp) begin
                    // A byte arriving on the expiry tick keeps the wait alive.
                    state_d = ST_FAIL;
                end
            end
            ST_DONE, ST_FAIL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_req_d     = is_tx_state(state_d) && (state_d != state_q);
        tx_byte_d    = tx_byte_q;
        if (tx_req_d) begin
            tx_byte_d = (state_d == ST_TX_CMD) ? cmd_d : arg_d;
        end
        host_done_d  = ((state_d == ST_DONE) || (state_d == ST_FAIL)) && !grant_led_q;
        host_err_d   = (state_d == ST_FAIL) && !grant_led_q;
        scan_valid_d = phy.phy_rx_valid && !rx_consume;
        scan_byte_d  = phy.phy_rx_valid ? phy.phy_rx_byte : scan_byte_q;

        led_pend_d   = led_pend_q;
        if (led_grant) begin
            led_pend_d = 1'b0;
        end else if (led_want || ((state_q == ST_FAIL) && grant_led_q)) begin
            led_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q      <= ST_IDLE;
            retry_q      <= '0;
            cmd_q        <= '0;
            arg_q        <= '0;
            has_arg_q    <= 1'b0;
            grant_led_q  <= 1'b0;
            last_host_q  <= 1'b1;
            led_sent_q   <= '0;
            led_pend_q   <= 1'b1;
            ref_q        <= '0;
            tx_req_q     <= 1'b0;
            tx_byte_q    <= '0;
            host_done_q  <= 1'b0;
            host_err_q   <= 1'b0;
            scan_valid_q <= 1'b0;
            scan_byte_q  <= '0;
        end else if (clk7_en) begin
            state_q      <= state_d;
            retry_q      <= retry_d;
            cmd_q        <= cmd_d;
            arg_q        <= arg_d;
            has_arg_q    <= has_arg_d;
            grant_led_q  <= grant_led_d;
            last_host_q  <= last_host_d;
            led_sent_q   <= led_sent_d;
            led_pend_q   <= led_pend_d;
            ref_q        <= ref_q + REF_W'(1);
            tx_req_q     <= tx_req_d;
            tx_byte_q    <= tx_byte_d;
            host_done_q  <= host_done_d;
            host_err_q   <= host_err_d;
            scan_valid_q <= scan_valid_d;
            scan_byte_q  <= scan_byte_d;
        end
    end

    assign phy.phy_tx_req  = tx_req_q;
    assign phy.phy_tx_byte = tx_byte_q;
    assign host_done       = host_done_q;
    assign host_err        = host_err_q;
    assign scan_valid      = scan_valid_q;
    assign scan_byte       = scan_byte_q;
    assign busy            = (state_q != ST_IDLE);

endmodule
